// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state codes and output-lane helpers for the serial NOR flash model.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_DREAD     = 8'h3B;
    localparam logic [7:0] CMD_QREAD     = 8'h6B;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

    typedef logic [2:0] state_t;
    localparam state_t ST_CMD    = 3'd0;
    localparam state_t ST_ADDR   = 3'd1;
    localparam state_t ST_DUMMY  = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_IGNORE = 3'd4;

    typedef enum logic [1:0] {
        LANE_X1 = 2'd0,
        LANE_X2 = 2'd1,
        LANE_X4 = 2'd2
    } lane_t;

    function automatic lane_t cmd_lanes(input logic [7:0] cmd);
        case (cmd)
            CMD_DREAD: return LANE_X2;
            CMD_QREAD: return LANE_X4;
            default:   return LANE_X1;
        endcase
    endfunction

    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_FAST_READ) ||
               (cmd == CMD_DREAD) || (cmd == CMD_QREAD);
    endfunction

    function automatic logic cmd_has_dummy(input logic [7:0] cmd);
        return (cmd == CMD_FAST_READ) || (cmd == CMD_DREAD) || (cmd == CMD_QREAD);
    endfunction

    // Falling edges per byte minus one, for the output bit counter.
    function automatic logic [2:0] lane_last_cycle(input lane_t lane);
        case (lane)
            LANE_X2: return 3'd3;
            LANE_X4: return 3'd1;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// Rising-edge input stage: shifts io0 MSB-first and counts SCK edges since the last restart.
module spi_flash_shifter
    import spi_flash_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din,
    input  logic             i_restart,
    output logic [23:0]      o_next,
    output logic [CNT_W-1:0] o_cnt
);

    logic [22:0]      r_shift;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= {r_shift[21:0], i_din};
            r_cnt   <= i_restart ? '0 : r_cnt + 1'b1;
        end
    end

    // Includes the bit being sampled now so the FSM can decode on the final edge.
    assign o_next = {r_shift, i_din};
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/spi_flash.sv
// Serial NOR flash slave: 1/2/4-lane reads and JEDEC ID, sampling on SCK rise, driving on SCK fall.
module spi_flash
    import spi_flash_pkg::*;
#(
    parameter int          MEM_BYTES    = 16777216,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter int          DUMMY_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       csb,
    inout  wire        io0,
    inout  wire        io1,
    inout  wire        io2,
    inout  wire        io3,
    output logic [2:0] o_dbg_state,
    output logic [3:0] o_dbg_oe
);

    localparam int MAW   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CNT_W = 8;

    reg [7:0] memory [0:MEM_BYTES-1];

    logic             w_rst;
    state_t           r_state;
    logic [7:0]       r_cmd;
    logic [MAW-1:0]   r_addr;
    logic [23:0]      w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_restart;

    // Deselect behaves exactly like reset for all transaction state.
    assign w_rst = rst | csb;

    always_comb begin
        w_restart = 1'b0;
        case (r_state)
            ST_CMD:   w_restart = (w_cnt == CNT_W'(7));
            ST_ADDR:  w_restart = (w_cnt == CNT_W'(23));
            ST_DUMMY: w_restart = (w_cnt == CNT_W'(DUMMY_CYCLES - 1));
            default:  w_restart = 1'b0;
        endcase
    end

    spi_flash_shifter #(.CNT_W(CNT_W)) u_shifter (
        .i_clk     (clk),
        .i_rst     (w_rst),
        .i_din     (io0),
        .i_restart (w_restart),
        .o_next    (w_next),
        .o_cnt     (w_cnt)
    );

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_CMD;
            r_cmd   <= '0;
            r_addr  <= '0;
        end else if (w_restart) begin
            case (r_state)
                ST_CMD: begin
                    r_cmd <= w_next[7:0];
                    if (cmd_is_read(w_next[7:0]))
                        r_state <= ST_ADDR;
                    else if (w_next[7:0] == CMD_RDID)
                        r_state <= ST_DATA;
                    else
                        r_state <= ST_IGNORE;
                end
                ST_ADDR: begin
                    r_addr  <= MAW'({8'd0, w_next} % MEM_BYTES);
                    r_state <= (cmd_has_dummy(r_cmd) && (DUMMY_CYCLES > 0)) ? ST_DUMMY : ST_DATA;
                end
                default: r_state <= ST_DATA;
            endcase
        end
    end

    lane_t          w_lane;
    logic [7:0]     r_obyte;
    logic [2:0]     r_ocnt;
    logic           r_first;
    logic [MAW-1:0] r_rd_addr;
    logic [1:0]     r_jidx;
    logic [3:0]     r_oe;
    logic [3:0]     r_dout;
    logic [MAW-1:0] w_src_addr;
    logic [7:0]     w_id_byte;
    logic [7:0]     w_cur;

    assign w_lane = cmd_lanes(r_cmd);

    // The first byte comes from the rising-edge address; later bytes from the falling-edge pointer.
    always_comb begin
        w_src_addr = r_first ? r_addr : r_rd_addr;
        case (r_jidx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            default: w_id_byte = JEDEC_ID[7:0];
        endcase
        if (r_ocnt != 3'd0)
            w_cur = r_obyte;
        else if (r_cmd == CMD_RDID)
            w_cur = w_id_byte;
        else
            w_cur = memory[w_src_addr];
    end

    always_ff @(negedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_oe      <= 4'b0000;
            r_dout    <= 4'b0000;
            r_obyte   <= '0;
            r_ocnt    <= '0;
            r_first   <= 1'b1;
            r_rd_addr <= '0;
            r_jidx    <= '0;
        end else if (r_state == ST_DATA) begin
            case (w_lane)
                LANE_X2: begin
                    r_oe    <= 4'b0011;
                    r_dout  <= {2'b00, w_cur[7:6]};
                    r_obyte <= {w_cur[5:0], 2'b00};
                end
                LANE_X4: begin
                    r_oe    <= 4'b1111;
                    r_dout  <= w_cur[7:4];
                    r_obyte <= {w_cur[3:0], 4'b0000};
                end
                default: begin
                    r_oe    <= 4'b0010;
                    r_dout  <= {2'b00, w_cur[7], 1'b0};
                    r_obyte <= {w_cur[6:0], 1'b0};
                end
            endcase
            if (r_ocnt == 3'd0) begin
                r_ocnt  <= lane_last_cycle(w_lane);
                r_first <= 1'b0;
                if (r_cmd == CMD_RDID)
                    r_jidx <= (r_jidx == 2'd2) ? 2'd0 : r_jidx + 2'd1;
                else
                    r_rd_addr <= (w_src_addr == MAW'(MEM_BYTES - 1)) ? '0 : w_src_addr + 1'b1;
            end else begin
                r_ocnt <= r_ocnt - 3'd1;
            end
        end else begin
            r_oe <= 4'b0000;
        end
    end

    assign io0 = r_oe[0] ? r_dout[0] : 1'bz;
    assign io1 = r_oe[1] ? r_dout[1] : 1'bz;
    assign io2 = r_oe[2] ? r_dout[2] : 1'bz;
    assign io3 = r_oe[3] ? r_dout[3] : 1'bz;

    assign o_dbg_state = r_state;
    assign o_dbg_oe    = r_oe;

endmodule

// File: tb/tb_spi_flash.sv
// Self-checking bench for spi_flash: directed reads on every command plus randomized transactions.
module tb_spi_flash;
    import spi_flash_pkg::*;

    logic       clk;
    logic       rst;
    logic       csb;
    wire        io0;
    wire        io1;
    wire        io2;
    wire        io3;
    logic [2:0] dbg_state;
    logic [3:0] dbg_oe;
    logic       tb_d0_en;
    logic       tb_d0;

    localparam logic [23:0] ID_VAL = 24'hEF4018;

    int n_checks;
    int n_fail;

    logic [7:0] ref_mem [int];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [3:0] chunk_q[$];

    assign io0 = tb_d0_en ? tb_d0 : 1'bz;

    spi_flash dut (
        .clk         (clk),
        .rst         (rst),
        .csb         (csb),
        .io0         (io0),
        .io1         (io1),
        .io2         (io2),
        .io3         (io3),
        .o_dbg_state (dbg_state),
        .o_dbg_oe    (dbg_oe)
    );

    // ---------------- reference model ----------------
    function automatic int lane_bits(input logic [7:0] cmd);
        if (cmd == 8'h3B) return 2;
        if (cmd == 8'h6B) return 4;
        return 1;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [7:0] cmd);
        if (cmd == 8'h3B) return 4'b0011;
        if (cmd == 8'h6B) return 4'b1111;
        return 4'b0010;
    endfunction

    function automatic int dummy_of(input logic [7:0] cmd);
        if (cmd == 8'h0B || cmd == 8'h3B || cmd == 8'h6B) return 8;
        return 0;
    endfunction

    function automatic logic is_read(input logic [7:0] cmd);
        return cmd == 8'h03 || cmd == 8'h0B || cmd == 8'h3B || cmd == 8'h6B;
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr, input int i);
        int a;
        logic [23:0] id;
        id = ID_VAL;
        if (cmd == 8'h9F) return id[8*(2 - (i % 3)) +: 8];
        a = (int'(addr) + i) % 16777216;
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input int addr, input logic [7:0] val);
        dut.memory[addr] = val;
        ref_mem[addr] = val;
    endtask

    task automatic spi_cycle(input logic en, input logic d, output logic [3:0] pins, output logic [3:0] oe);
        tb_d0_en = en;
        tb_d0    = d;
        #5;
        pins = {io3, io2, io1, io0};
        oe   = dbg_oe;
        clk  = 1'b1;
        #10;
        clk      = 1'b0;
        tb_d0_en = 1'b0;
        #5;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int ndata, output int oe_err);
        logic [3:0] pins;
        logic [3:0] oe;
        oe_err = 0;
        chunk_q.delete();
        csb = 1'b0;
        #5;
        for (int i = 0; i < 8; i++) begin
            spi_cycle(1'b1, cmd[7-i], pins, oe);
            if (oe !== 4'b0000) oe_err++;
        end
        if (is_read(cmd)) begin
            for (int i = 0; i < 24; i++) begin
                spi_cycle(1'b1, addr[23-i], pins, oe);
                if (oe !== 4'b0000) oe_err++;
            end
            for (int i = 0; i < dummy_of(cmd); i++) begin
                spi_cycle(1'b1, 1'($urandom_range(0, 1)), pins, oe);
                if (oe !== 4'b0000) oe_err++;
            end
        end
        for (int i = 0; i < ndata; i++) begin
            spi_cycle(1'b0, 1'b0, pins, oe);
            if (oe !== lane_mask(cmd)) oe_err++;
            chunk_q.push_back(pins & lane_mask(cmd));
        end
    endtask

    task automatic end_xfer();
        csb = 1'b1;
        #10;
    endtask

    task automatic assemble(input logic [7:0] cmd);
        int w;
        logic [7:0] b;
        logic [3:0] ch;
        w = lane_bits(cmd);
        got_q.delete();
        while (chunk_q.size() >= 8 / w) begin
            b = 8'h00;
            for (int c = 0; c < 8 / w; c++) begin
                ch = chunk_q.pop_front();
                case (w)
                    1:       b = {b[6:0], ch[1]};
                    2:       b = {b[5:0], ch[1:0]};
                    default: b = {b[3:0], ch};
                endcase
            end
            got_q.push_back(b);
        end
    endtask

    task automatic load_expected(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        exp_q.delete();
        for (int i = 0; i < nbytes; i++) exp_q.push_back(model_byte(cmd, addr, i));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] pins;
        logic [3:0] oe;
        clk = 1'b0; rst = 1'b1; csb = 1'b1; tb_d0_en = 1'b0; tb_d0 = 1'b0;
        #10;
        n_checks++;
        if (dbg_oe !== 4'b0000) begin
            n_fail++; $display("FAIL reset_oe got %b expected 0000", dbg_oe);
        end
        n_checks++;
        if (dbg_state !== ST_CMD) begin
            n_fail++; $display("FAIL reset_state got %0d expected %0d", dbg_state, ST_CMD);
        end
        rst = 1'b0;
        #10;
        for (int i = 0; i < 8; i++) spi_cycle(1'b1, 1'b1, pins, oe);
        n_checks++;
        if (dbg_state !== ST_CMD || dbg_oe !== 4'b0000) begin
            n_fail++; $display("FAIL csb_holds_idle got state %0d oe %b expected %0d 0000", dbg_state, dbg_oe, ST_CMD);
        end
    endtask

    task automatic test_read_basic();
        int oe_err;
        logic [31:0] word;
        preload(0, 8'h6F); preload(1, 8'h00); preload(2, 8'h00); preload(3, 8'h00);
        xfer(8'h03, 24'h000000, 32, oe_err);
        end_xfer();
        assemble(8'h03);
        word = {got_q[0], got_q[1], got_q[2], got_q[3]};
        n_checks++;
        if (word !== 32'h6F000000) begin
            n_fail++; $display("FAIL read03_word got %h expected 6f000000", word);
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL read03_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_fast_read_wrap();
        int oe_err;
        preload(24'hFFFFFF, 8'($urandom_range(0, 255)));
        xfer(8'h0B, 24'hFFFFFF, 16, oe_err);
        end_xfer();
        assemble(8'h0B);
        load_expected(8'h0B, 24'hFFFFFF, 2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fast_wrap byte%0d got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL fast_wrap_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_quad();
        int oe_err;
        logic [7:0] eb;
        logic [3:0] en;
        preload(24'h000100, 8'hA5); preload(24'h000101, 8'h3C);
        xfer(8'h6B, 24'h000100, 4, oe_err);
        end_xfer();
        for (int k = 0; k < 4; k++) begin
            eb = model_byte(8'h6B, 24'h000100, k / 2);
            en = (k % 2 == 0) ? eb[7:4] : eb[3:0];
            n_checks++;
            if (chunk_q[k] !== en) begin
                n_fail++; $display("FAIL quad_nibble%0d got %h expected %h", k, chunk_q[k], en);
            end
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL quad_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_dual();
        int oe_err;
        logic [7:0] eb;
        logic [1:0] ep;
        preload(24'h000020, 8'hB4);
        xfer(8'h3B, 24'h000020, 4, oe_err);
        end_xfer();
        eb = model_byte(8'h3B, 24'h000020, 0);
        for (int k = 0; k < 4; k++) begin
            ep = eb[7 - 2*k -: 2];
            n_checks++;
            if (chunk_q[k][1:0] !== ep) begin
                n_fail++; $display("FAIL dual_pair%0d got %b expected %b", k, chunk_q[k][1:0], ep);
            end
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL dual_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_jedec();
        int oe_err;
        xfer(8'h9F, 24'h0, 48, oe_err);
        end_xfer();
        assemble(8'h9F);
        load_expected(8'h9F, 24'h0, 6);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL jedec byte%0d got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL jedec_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_abort();
        int oe_err;
        preload(24'h000040, 8'h81);
        preload(4, 8'($urandom_range(0, 255)));
        preload(5, 8'($urandom_range(0, 255)));
        xfer(8'h03, 24'h000040, 3, oe_err);
        csb = 1'b1;
        #1;
        n_checks++;
        if (dbg_oe !== 4'b0000 || dbg_state !== ST_CMD) begin
            n_fail++; $display("FAIL abort_release got oe %b state %0d expected 0000 %0d", dbg_oe, dbg_state, ST_CMD);
        end
        #9;
        xfer(8'h03, 24'h000004, 16, oe_err);
        end_xfer();
        assemble(8'h03);
        load_expected(8'h03, 24'h000004, 2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL after_abort byte%0d got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (oe_err != 0) begin
            n_fail++; $display("FAIL after_abort_lanes got %0d bad oe samples expected 0", oe_err);
        end
    endtask

    task automatic test_rst_mid_data();
        int oe_err;
        xfer(8'h6B, 24'h000100, 2, oe_err);
        n_checks++;
        if (dbg_oe !== 4'b1111) begin
            n_fail++; $display("FAIL rst_pre_oe got %b expected 1111", dbg_oe);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dbg_oe !== 4'b0000 || dbg_state !== ST_CMD) begin
            n_fail++; $display("FAIL rst_async got oe %b state %0d expected 0000 %0d", dbg_oe, dbg_state, ST_CMD);
        end
        #4;
        rst = 1'b0;
        end_xfer();
    endtask

    task automatic test_ignore();
        int oe_err;
        logic [3:0] pins;
        logic [3:0] oe;
        int bad;
        bad = 0;
        xfer(8'hAB, 24'h0, 0, oe_err);
        for (int i = 0; i < 40; i++) begin
            spi_cycle(1'b1, 1'($urandom_range(0, 1)), pins, oe);
            if (oe !== 4'b0000) bad++;
        end
        n_checks++;
        if (bad != 0 || oe_err != 0) begin
            n_fail++; $display("FAIL ignore_quiet got %0d driven samples expected 0", bad + oe_err);
        end
        n_checks++;
        if (dbg_state !== ST_IGNORE) begin
            n_fail++; $display("FAIL ignore_state got %0d expected %0d", dbg_state, ST_IGNORE);
        end
        end_xfer();
    endtask

    task automatic test_random();
        logic [7:0] cmds [5];
        logic [7:0] cmd;
        logic [23:0] addr;
        int nbytes;
        int oe_err;
        cmds[0] = 8'h03; cmds[1] = 8'h0B; cmds[2] = 8'h3B; cmds[3] = 8'h6B; cmds[4] = 8'h9F;
        for (int t = 0; t < 25; t++) begin
            cmd    = cmds[$urandom_range(0, 4)];
            addr   = 24'($urandom());
            nbytes = $urandom_range(1, 5);
            for (int i = 0; i < nbytes; i++)
                preload((int'(addr) + i) % 16777216, 8'($urandom_range(0, 255)));
            xfer(cmd, addr, nbytes * (8 / lane_bits(cmd)), oe_err);
            end_xfer();
            assemble(cmd);
            load_expected(cmd, addr, nbytes);
            for (int i = 0; i < nbytes; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d cmd %h addr %h byte%0d got %h expected %h", t, cmd, addr, i, got_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (oe_err != 0) begin
                n_fail++; $display("FAIL rand%0d_lanes cmd %h got %0d bad oe samples expected 0", t, cmd, oe_err);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read_basic();
        test_fast_read_wrap();
        test_quad();
        test_dual();
        test_jedec();
        test_abort();
        test_rst_mid_data();
        test_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
